// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the 12-bit to 8-bit floating-point converter.
// Word format: sign, 3-bit exponent E, 4-bit significand F, value = F * 2^E.
package fpcvt_pkg;

  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int LZ_W  = 4;

  localparam logic [EXP_W-1:0] EXP_MAX  = 3'd7;
  localparam logic [MAN_W-1:0] MAN_MAX  = 4'd15;
  localparam logic [MAN_W-1:0] MAN_HALF = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    ENC,
    RND,
    DONE
  } state_t;

endpackage

// File: rtl/leading_one_detect.sv
// Combinational leading-one detector: counts leading zeros of the magnitude and
// extracts the 4-bit significand starting at the leading one plus the round bit.
module leading_one_detect
  import fpcvt_pkg::*;
(
  input  logic [IN_W-1:0]  mag,
  output logic [LZ_W-1:0]  lz,
  output logic [MAN_W-1:0] f,
  output logic             r
);

  localparam int WIN_W = MAN_W + 1;

  logic             found;
  logic [WIN_W-1:0] window;

  always_comb begin
    lz    = LZ_W'(IN_W);
    found = 1'b0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (!found && mag[i]) begin
        lz    = LZ_W'(IN_W - 1 - i);
        found = 1'b1;
      end
    end
  end

  // Small magnitudes (lz >= 8) are taken verbatim with E = 0 and no rounding.
  always_comb begin
    window = '0;
    f      = mag[MAN_W-1:0];
    r      = 1'b0;
    if (lz < LZ_W'(2 ** EXP_W)) begin
      window = WIN_W'(mag >> (LZ_W'(IN_W - MAN_W - 1) - lz));
      f      = window[WIN_W-1:1];
      r      = window[0];
    end
  end

endmodule

// File: rtl/fpcvt_sequencer.sv
// Multi-cycle sample-to-float converter: IDLE -> ABS -> ENC -> RND -> DONE,
// sharing one leading-one detector, with valid/ready handshakes on both sides.
module fpcvt_sequencer
  import fpcvt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_f,
  output logic             out_sat,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [IN_W-1:0]  sample_q, sample_d;
  logic [IN_W-1:0]  mag_q, mag_d;
  logic             sat_q, sat_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [MAN_W-1:0] f_q, f_d;
  logic             r_q, r_d;
  logic             out_s_q, out_s_d;
  logic [EXP_W-1:0] out_e_q, out_e_d;
  logic [MAN_W-1:0] out_f_q, out_f_d;
  logic             out_sat_q, out_sat_d;

  logic [LZ_W-1:0]  lod_lz;
  logic [MAN_W-1:0] lod_f;
  logic             lod_r;
  logic [MAN_W:0]   f_sum;
  logic [EXP_W:0]   e_sum;
  logic [MAN_W-1:0] f_rnd;

  leading_one_detect u_lod (
    .mag (mag_q),
    .lz  (lod_lz),
    .f   (lod_f),
    .r   (lod_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sample_q  <= '0;
      mag_q     <= '0;
      sat_q     <= 1'b0;
      e_q       <= '0;
      f_q       <= '0;
      r_q       <= 1'b0;
      out_s_q   <= 1'b0;
      out_e_q   <= '0;
      out_f_q   <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      mag_q     <= mag_d;
      sat_q     <= sat_d;
      e_q       <= e_d;
      f_q       <= f_d;
      r_q       <= r_d;
      out_s_q   <= out_s_d;
      out_e_q   <= out_e_d;
      out_f_q   <= out_f_d;
      out_sat_q <= out_sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ABS;
      ABS:     state_d = ENC;
      ENC:     state_d = RND;
      RND:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_s     = out_s_q;
    out_e     = out_e_q;
    out_f     = out_f_q;
    out_sat   = out_sat_q;
  end

  // Rounding carry: F overflowing to 16 renormalises to 8 with E+1; E overflowing saturates.
  always_comb begin
    f_sum = {1'b0, f_q} + {{MAN_W{1'b0}}, r_q};
    e_sum = {1'b0, e_q};
    f_rnd = f_sum[MAN_W-1:0];
    if (f_sum[MAN_W]) begin
      f_rnd = MAN_HALF;
      e_sum = {1'b0, e_q} + {{EXP_W{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    sample_d  = sample_q;
    mag_d     = mag_q;
    sat_d     = sat_q;
    e_d       = e_q;
    f_d       = f_q;
    r_d       = r_q;
    out_s_d   = out_s_q;
    out_e_d   = out_e_q;
    out_f_d   = out_f_q;
    out_sat_d = out_sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sample_d  = in_d;
          sat_d     = 1'b0;
          out_sat_d = 1'b0;
        end
      end
      ABS: begin
        out_s_d = sample_q[IN_W-1];
        sat_d   = 1'b0;
        // The most negative sample has no positive twin; clamp it to the largest magnitude.
        if (sample_q == {1'b1, {(IN_W-1){1'b0}}}) begin
          mag_d = {1'b0, {(IN_W-1){1'b1}}};
          sat_d = 1'b1;
        end else if (sample_q[IN_W-1]) begin
          mag_d = (~sample_q) + {{(IN_W-1){1'b0}}, 1'b1};
        end else begin
          mag_d = sample_q;
        end
      end
      ENC: begin
        e_d = (lod_lz >= LZ_W'(2 ** EXP_W)) ? '0 : EXP_W'(LZ_W'(2 ** EXP_W) - lod_lz);
        f_d = lod_f;
        r_d = lod_r;
      end
      RND: begin
        if (e_sum[EXP_W]) begin
          out_e_d   = EXP_MAX;
          out_f_d   = MAN_MAX;
          out_sat_d = 1'b1;
        end else begin
          out_e_d   = e_sum[EXP_W-1:0];
          out_f_d   = f_rnd;
          out_sat_d = sat_q;
        end
      end
      default: ;
    endcase
  end

endmodule
